s510_timing_sequencer: RTL and testbench

- Counter/compare sequencer feeding the s510 sync controller.
- Owns the line counter (cnt) and the pixel counter (pcnt).
- Decodes the fixed compare strobes that s510 samples: cnt10…cnt591 and pcnt6…pcnt241.
- Consumes s510's pclr, pc, cclr and csm to clear, advance and arm the counters; adds run-control FSM and overflow error detection.

---
 rtl/s510_timing_sequencer_pkg.sv | 33 +++
 rtl/s510_timing_sequencer_counter.sv | 39 +++
 rtl/s510_timing_sequencer.sv | 127 ++++++++++++
 tb/tb_s510_timing_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/s510_timing_sequencer_pkg.sv
// Shared types and compare constants for the s510 timing sequencer.
package s510_timing_pkg;

    typedef enum logic [1:0] {
        StOff = 2'b00,
        StArm = 2'b01,
        StRun = 2'b10
    } state_e;

    localparam int unsigned CNT_W_DEF  = 10;
    localparam int unsigned PCNT_W_DEF = 8;

    localparam int unsigned CNT_10  = 10;
    localparam int unsigned CNT_13  = 13;
    localparam int unsigned CNT_21  = 21;
    localparam int unsigned CNT_44  = 44;
    localparam int unsigned CNT_45  = 45;
    localparam int unsigned CNT_261 = 261;
    localparam int unsigned CNT_272 = 272;
    localparam int unsigned CNT_283 = 283;
    localparam int unsigned CNT_284 = 284;
    localparam int unsigned CNT_509 = 509;
    localparam int unsigned CNT_511 = 511;
    localparam int unsigned CNT_567 = 567;
    localparam int unsigned CNT_591 = 591;

    localparam int unsigned PCNT_6   = 6;
    localparam int unsigned PCNT_12  = 12;
    localparam int unsigned PCNT_17  = 17;
    localparam int unsigned PCNT_27  = 27;
    localparam int unsigned PCNT_241 = 241;

endpackage

// File: rtl/s510_timing_sequencer_counter.sv
// Clearable up-counter with wrap detect; forced to zero whenever run is low.
module timing_counter #(
    parameter int unsigned W = 8
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         run,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] val,
    output logic         wrap
);

    logic [W-1:0] r_val;
    logic [W-1:0] w_val_nxt;

    // A clear in the same cycle suppresses the wrap, so wrap only fires on a real rollover.
    always_comb begin
        w_val_nxt = r_val;
        wrap      = 1'b0;
        if (!run || clr) begin
            w_val_nxt = '0;
        end else if (inc) begin
            w_val_nxt = r_val + 1'b1;
            wrap      = &r_val;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_val <= '0;
        end else begin
            r_val <= w_val_nxt;
        end
    end

    assign val = r_val;

endmodule

// File: rtl/s510_timing_sequencer.sv
// Line/pixel counter sequencer with compare strobes, run-control FSM and sticky wrap error.
module s510_timing_sequencer
    import s510_timing_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PCNT_W = PCNT_W_DEF
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              en,
    input  logic              csm,
    input  logic              pc,
    input  logic              pclr,
    input  logic              cclr,
    input  logic              err_clr,
    output logic              cnt10,
    output logic              cnt13,
    output logic              cnt21,
    output logic              cnt44,
    output logic              cnt45,
    output logic              cnt261,
    output logic              cnt272,
    output logic              cnt283,
    output logic              cnt284,
    output logic              cnt509,
    output logic              cnt511,
    output logic              cnt567,
    output logic              cnt591,
    output logic              pcnt6,
    output logic              pcnt12,
    output logic              pcnt17,
    output logic              pcnt27,
    output logic              pcnt241,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [PCNT_W-1:0] pcnt_val,
    output logic [1:0]        state,
    output logic              err
);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_err;
    logic   w_run;
    logic   w_wrap_c;
    logic   w_wrap_p;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StOff: if (en) w_state_nxt = StArm;
            StArm: begin
                if (!en) begin
                    w_state_nxt = StOff;
                end else if (csm) begin
                    w_state_nxt = StRun;
                end
            end
            StRun: if (!en) w_state_nxt = StOff;
            default: w_state_nxt = StOff;
        endcase
    end

    // Dropping en in RUN zeroes both counters on the same edge that leaves RUN.
    assign w_run = (r_state == StRun) && en;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= StOff;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wrap_c || w_wrap_p) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    timing_counter #(
        .W (CNT_W)
    ) u_line_cnt (
        .CK   (CK),
        .RST  (RST),
        .run  (w_run),
        .clr  (cclr),
        .inc  (1'b1),
        .val  (cnt_val),
        .wrap (w_wrap_c)
    );

    timing_counter #(
        .W (PCNT_W)
    ) u_pix_cnt (
        .CK   (CK),
        .RST  (RST),
        .run  (w_run),
        .clr  (pclr),
        .inc  (pc),
        .val  (pcnt_val),
        .wrap (w_wrap_p)
    );

    assign cnt10   = (cnt_val == CNT_W'(CNT_10));
    assign cnt13   = (cnt_val == CNT_W'(CNT_13));
    assign cnt21   = (cnt_val == CNT_W'(CNT_21));
    assign cnt44   = (cnt_val == CNT_W'(CNT_44));
    assign cnt45   = (cnt_val == CNT_W'(CNT_45));
    assign cnt261  = (cnt_val == CNT_W'(CNT_261));
    assign cnt272  = (cnt_val == CNT_W'(CNT_272));
    assign cnt283  = (cnt_val == CNT_W'(CNT_283));
    assign cnt284  = (cnt_val == CNT_W'(CNT_284));
    assign cnt509  = (cnt_val == CNT_W'(CNT_509));
    assign cnt511  = (cnt_val == CNT_W'(CNT_511));
    assign cnt567  = (cnt_val == CNT_W'(CNT_567));
    assign cnt591  = (cnt_val == CNT_W'(CNT_591));

    assign pcnt6   = (pcnt_val == PCNT_W'(PCNT_6));
    assign pcnt12  = (pcnt_val == PCNT_W'(PCNT_12));
    assign pcnt17  = (pcnt_val == PCNT_W'(PCNT_17));
    assign pcnt27  = (pcnt_val == PCNT_W'(PCNT_27));
    assign pcnt241 = (pcnt_val == PCNT_W'(PCNT_241));

    assign state = r_state;
    assign err   = r_err;

endmodule

// File: tb/tb_s510_timing_sequencer.sv
// Randomized and directed checks of s510_timing_sequencer against a cycle-level reference model.
module tb_s510_timing_sequencer;

    localparam int CMAX = 1023;
    localparam int PMAX = 255;

    logic CK = 1'b0;
    logic RST, en, csm, pc, pclr, cclr, err_clr;
    logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272, cnt283, cnt284;
    logic cnt509, cnt511, cnt567, cnt591;
    logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;
    logic [9:0] cnt_val;
    logic [7:0] pcnt_val;
    logic [1:0] state;
    logic       err;

    s510_timing_sequencer dut (
        .CK (CK), .RST (RST), .en (en), .csm (csm), .pc (pc), .pclr (pclr),
        .cclr (cclr), .err_clr (err_clr),
        .cnt10 (cnt10), .cnt13 (cnt13), .cnt21 (cnt21), .cnt44 (cnt44), .cnt45 (cnt45),
        .cnt261 (cnt261), .cnt272 (cnt272), .cnt283 (cnt283), .cnt284 (cnt284),
        .cnt509 (cnt509), .cnt511 (cnt511), .cnt567 (cnt567), .cnt591 (cnt591),
        .pcnt6 (pcnt6), .pcnt12 (pcnt12), .pcnt17 (pcnt17), .pcnt27 (pcnt27),
        .pcnt241 (pcnt241),
        .cnt_val (cnt_val), .pcnt_val (pcnt_val), .state (state), .err (err)
    );

    always #5 CK = ~CK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0=off, 1=armed, 2=running
    int m_mode, m_cnt, m_pcnt;
    bit m_err;

    int cnt_k[13]  = '{10, 13, 21, 44, 45, 261, 272, 283, 284, 509, 511, 567, 591};
    int pcnt_k[5]  = '{6, 12, 17, 27, 241};

    task automatic check_eq(input string tag, input longint unsigned act,
                            input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pcnt = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit wrapped;
        int nm;
        wrapped = 0;
        nm = 0;
        case (m_mode)
            0: begin m_cnt = 0; m_pcnt = 0; nm = en ? 1 : 0; end
            1: nm = !en ? 0 : (csm ? 2 : 1);
            2: begin
                if (!en) begin
                    nm = 0; m_cnt = 0; m_pcnt = 0;
                end else begin
                    nm = 2;
                    if (cclr) m_cnt = 0;
                    else if (m_cnt == CMAX) begin m_cnt = 0; wrapped = 1; end
                    else m_cnt = m_cnt + 1;
                    if (pclr) m_pcnt = 0;
                    else if (pc) begin
                        if (m_pcnt == PMAX) begin m_pcnt = 0; wrapped = 1; end
                        else m_pcnt = m_pcnt + 1;
                    end
                end
            end
            default: nm = 0;
        endcase
        if (wrapped) m_err = 1;
        else if (err_clr) m_err = 0;
        m_mode = nm;
    endtask

    task automatic check_all();
        logic [12:0] cs, exp_cs;
        logic [4:0]  ps, exp_ps;
        cs = {cnt591, cnt567, cnt511, cnt509, cnt284, cnt283, cnt272, cnt261,
              cnt45, cnt44, cnt21, cnt13, cnt10};
        ps = {pcnt241, pcnt27, pcnt17, pcnt12, pcnt6};
        for (int i = 0; i < 13; i++) exp_cs[i] = (m_cnt == cnt_k[i]);
        for (int i = 0; i < 5; i++)  exp_ps[i] = (m_pcnt == pcnt_k[i]);
        check_eq("state", state, m_mode);
        check_eq("cnt_val", cnt_val, m_cnt);
        check_eq("pcnt_val", pcnt_val, m_pcnt);
        check_eq("err", err, m_err);
        check_eq("cnt_strobes", cs, exp_cs);
        check_eq("pcnt_strobes", ps, exp_ps);
    endtask

    task automatic cycle();
        @(posedge CK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run_until_cnt(input int target);
        int n;
        n = 0;
        while (!(m_mode == 2 && m_cnt == target) && n < 2100) begin
            cycle();
            n++;
        end
        check_eq("wait_cnt", cnt_val, target);
    endtask

    task automatic arm_and_run();
        en = 1'b1;
        cycle();
        cycle();
        csm = 1'b1;
        cycle();
        csm = 1'b0;
    endtask

    initial begin
        RST = 1'b1; en = 0; csm = 0; pc = 0; pclr = 0; cclr = 0; err_clr = 0;
        model_reset();
        #12;
        check_all();
        @(negedge CK);
        RST = 1'b0;

        // Armed without sync mark stays idle at zero.
        en = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("armed_state", state, 1);
        csm = 1'b1;
        cycle();
        csm = 1'b0;
        check_eq("run_entry", state, 2);
        cycle();
        check_eq("first_count", cnt_val, 1);

        // Walk through every line strobe.
        run_until_cnt(600);

        // Pixel clear beats pc in the same cycle.
        pclr = 1'b1; cycle(); pclr = 1'b0;
        pc = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check_eq("pcnt6_hit", pcnt6, 1);
        pclr = 1'b1;
        cycle();
        pclr = 1'b0; pc = 1'b0;
        check_eq("pclr_wins", pcnt_val, 0);

        // Line counter rollover sets err; err_clr then clears it.
        run_until_cnt(CMAX);
        cycle();
        check_eq("line_wrap_err", err, 1);
        err_clr = 1'b1; cycle(); err_clr = 1'b0;
        check_eq("err_cleared", err, 0);

        // cclr at the top value suppresses the wrap error.
        run_until_cnt(CMAX);
        cclr = 1'b1; cycle(); cclr = 1'b0;
        check_eq("cclr_no_err", err, 0);

        // Pixel rollover, then pclr at top with pc suppresses it.
        pc = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        err_clr = 1'b1; pc = 1'b0; cycle(); err_clr = 1'b0;
        pc = 1'b1;
        while (m_pcnt != PMAX) cycle();
        pclr = 1'b1; cycle(); pclr = 1'b0; pc = 1'b0;
        check_eq("pclr_no_err", err, 0);

        // Disable mid-run.
        run_until_cnt(300);
        en = 1'b0;
        cycle();
        check_eq("disable_cnt", cnt_val, 0);

        // Asynchronous reset between edges.
        arm_and_run();
        run_until_cnt(500);
        #3 RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge CK);
        #1;
        check_all();
        #2 RST = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(99) < 98);
            csm     = ($urandom_range(99) < 10);
            pc      = ($urandom_range(99) < 60);
            pclr    = ($urandom_range(999) < 5);
            cclr    = ($urandom_range(999) < 2);
            err_clr = ($urandom_range(99) < 2);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
